// File: rtl/cpu_datapath.sv
// cpu_datapath
// Bus-based 32-bit CPU datapath: 16x32 register file, PC, IR, MAR, MDR, HI,
// LO, Y, 64-bit Z (ZHigh/ZLow), input and output port registers, and a
// combinational ALU. All transfers go over one 32-bit bus. An external
// controller sequences every select and load enable cycle by cycle.
//
// Ports
//   clk, clear             rising-edge clock, synchronous active-high reset
//   opcode[4:0]            ALU operation (A = Y, B = bus)
//   enable[15:0]           register-file load enables (bit n = Rn)
//   r3in, r4in, r7in       extra load enables ORed into R3, R4, R7
//   Rout[15:0]             register-file bus-source selects
//   PCout..Cout            other bus-source selects (fixed priority)
//   PC_enable..OutPort_enable, MDRin, ZHigh_enable, ZLow_enable
//                          register load enables
//   mdr_read               MDR source: 1 = Mdatain, 0 = bus
//   Mdatain                memory read data
//   InPort_data_in         input-port data, sampled every cycle
//   RY_immediate           immediate value placed on the bus by Cout
//   bus_data               current bus value
//   OutPort_data_out       output-port register
//   *_debug                direct views of R3, R4, R7, PC, ZHigh, ZLow

module cpu_datapath (
    input  logic        clk,
    input  logic        clear,
    input  logic [4:0]  opcode,
    input  logic [15:0] enable,
    input  logic        r3in,
    input  logic        r4in,
    input  logic        r7in,
    input  logic [15:0] Rout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        ZHighout,
    input  logic        ZLowout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        InPortout,
    input  logic        Cout,
    input  logic        PC_enable,
    input  logic        MAR_enable,
    input  logic        IR_enable,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        OutPort_enable,
    input  logic        MDRin,
    input  logic        mdr_read,
    input  logic        ZHigh_enable,
    input  logic        ZLow_enable,
    input  logic [31:0] Mdatain,
    input  logic [31:0] InPort_data_in,
    input  logic [31:0] RY_immediate,
    output logic [31:0] bus_data,
    output logic [31:0] OutPort_data_out,
    output logic [31:0] r3_debug,
    output logic [31:0] r4_debug,
    output logic [31:0] r7_debug,
    output logic [31:0] pc_debug,
    output logic [31:0] ZHigh_debug,
    output logic [31:0] ZLow_debug
);

    logic [31:0] rf [16];
    logic [31:0] pc, ir, mar, mdr, hi, lo, y, zhigh, zlow, outport, inport;
    logic [15:0] rf_load;
    logic [63:0] z;

    // ALU intermediates
    logic [63:0]        a_ext, b_ext;
    logic signed [31:0] a_s, b_s, div_q, div_r;
    logic [4:0]         sh;

    assign rf_load = enable | {8'b0, r7in, 2'b0, r4in, r3in, 3'b0};

    // Bus mux written lowest priority first so the highest-priority
    // asserted source is the last assignment and wins.
    always_comb begin
        bus_data = '0;
        for (int i = 15; i >= 0; i--) begin
            if (Rout[i]) bus_data = rf[i];
        end
        if (Cout)      bus_data = RY_immediate;
        if (InPortout) bus_data = inport;
        if (LOout)     bus_data = lo;
        if (HIout)     bus_data = hi;
        if (ZLowout)   bus_data = zlow;
        if (ZHighout)  bus_data = zhigh;
        if (MDRout)    bus_data = mdr;
        if (PCout)     bus_data = pc;
    end

    // Sign-extending both operands to 64 bits makes the low 64 bits of an
    // unsigned product equal to the signed 32x32 product.
    always_comb begin
        a_ext = {{32{y[31]}}, y};
        b_ext = {{32{bus_data[31]}}, bus_data};
        a_s   = y;
        b_s   = bus_data;
        sh    = bus_data[4:0];
        div_q = '0;
        div_r = '0;
        if (b_s != 0) begin
            div_q = a_s / b_s;
            div_r = a_s % b_s;
        end
    end

    always_comb begin
        z = {32'b0, bus_data};
        case (opcode)
            5'b00000: z = {32'b0, y + bus_data};
            5'b00001: z = {32'b0, y - bus_data};
            5'b00010: z = {32'b0, y & bus_data};
            5'b00011: z = {32'b0, y | bus_data};
            5'b00100: z = a_ext * b_ext;
            5'b00101: z = {div_r, div_q};
            5'b00110: z = {32'b0, y >> sh};
            5'b00111: z = {32'b0, 32'($signed(y) >>> sh)};
            5'b01000: z = {32'b0, y << sh};
            // A shift by 32 yields 0, so a zero rotate amount degenerates cleanly.
            5'b01001: z = {32'b0, (y >> sh) | (y << (6'd32 - {1'b0, sh}))};
            5'b01010: z = {32'b0, (y << sh) | (y >> (6'd32 - {1'b0, sh}))};
            5'b01011: z = {32'b0, 32'd0 - bus_data};
            5'b01100: z = {32'b0, ~bus_data};
            5'b01101: z = {32'b0, bus_data + 32'd1};
            default:  z = {32'b0, bus_data};
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            pc      <= '0;
            ir      <= '0;
            mar     <= '0;
            mdr     <= '0;
            hi      <= '0;
            lo      <= '0;
            y       <= '0;
            zhigh   <= '0;
            zlow    <= '0;
            outport <= '0;
            inport  <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (rf_load[i]) rf[i] <= bus_data;
            end
            if (PC_enable)      pc      <= bus_data;
            if (IR_enable)      ir      <= bus_data;
            if (MAR_enable)     mar     <= bus_data;
            if (MDRin)          mdr     <= mdr_read ? Mdatain : bus_data;
            if (HIin)           hi      <= bus_data;
            if (LOin)           lo      <= bus_data;
            if (Yin)            y       <= bus_data;
            if (ZHigh_enable)   zhigh   <= z[63:32];
            if (ZLow_enable)    zlow    <= z[31:0];
            if (OutPort_enable) outport <= bus_data;
            inport <= InPort_data_in;
        end
    end

    assign OutPort_data_out = outport;
    assign r3_debug         = rf[3];
    assign r4_debug         = rf[4];
    assign r7_debug         = rf[7];
    assign pc_debug         = pc;
    assign ZHigh_debug      = zhigh;
    assign ZLow_debug       = zlow;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath
// Drives the datapath the way a controller would, one micro-step per clock.
// Expected values are pushed onto a queue when a step is driven and popped
// and compared once the step has taken effect.

module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        clear;
    logic [4:0]  opcode;
    logic [15:0] enable;
    logic        r3in, r4in, r7in;
    logic [15:0] Rout;
    logic        PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout;
    logic        PC_enable, MAR_enable, IR_enable, Yin, HIin, LOin, OutPort_enable;
    logic        MDRin, mdr_read, ZHigh_enable, ZLow_enable;
    logic [31:0] Mdatain, InPort_data_in, RY_immediate;
    logic [31:0] bus_data, OutPort_data_out;
    logic [31:0] r3_debug, r4_debug, r7_debug, pc_debug, ZHigh_debug, ZLow_debug;

    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk(clk), .clear(clear), .opcode(opcode), .enable(enable),
        .r3in(r3in), .r4in(r4in), .r7in(r7in), .Rout(Rout),
        .PCout(PCout), .MDRout(MDRout), .ZHighout(ZHighout), .ZLowout(ZLowout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .PC_enable(PC_enable), .MAR_enable(MAR_enable), .IR_enable(IR_enable),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPort_enable(OutPort_enable),
        .MDRin(MDRin), .mdr_read(mdr_read), .ZHigh_enable(ZHigh_enable),
        .ZLow_enable(ZLow_enable), .Mdatain(Mdatain), .InPort_data_in(InPort_data_in),
        .RY_immediate(RY_immediate), .bus_data(bus_data),
        .OutPort_data_out(OutPort_data_out), .r3_debug(r3_debug), .r4_debug(r4_debug),
        .r7_debug(r7_debug), .pc_debug(pc_debug), .ZHigh_debug(ZHigh_debug),
        .ZLow_debug(ZLow_debug)
    );

    task automatic idle();
        clear = 0; opcode = 5'b0; enable = '0; r3in = 0; r4in = 0; r7in = 0; Rout = '0;
        PCout = 0; MDRout = 0; ZHighout = 0; ZLowout = 0; HIout = 0; LOout = 0;
        InPortout = 0; Cout = 0; PC_enable = 0; MAR_enable = 0; IR_enable = 0;
        Yin = 0; HIin = 0; LOin = 0; OutPort_enable = 0; MDRin = 0; mdr_read = 0;
        ZHigh_enable = 0; ZLow_enable = 0; Mdatain = '0; RY_immediate = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] obs [8];
        idle();
        Cout = 1; RY_immediate = 32'hDEADBEEF; enable = 16'hFFFF; PC_enable = 1;
        Yin = 1; HIin = 1; LOin = 1; OutPort_enable = 1; opcode = 5'b01100;
        ZLow_enable = 1; ZHigh_enable = 1;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h21524110);
        tick();
        exp_v = exp_q.pop_front(); total++;
        if (r3_debug !== exp_v) begin $display("[TB] FAIL preload_r3 got=%h exp=%h", r3_debug, exp_v); bad++; end
        exp_v = exp_q.pop_front(); total++;
        if (ZLow_debug !== exp_v) begin $display("[TB] FAIL preload_zlow got=%h exp=%h", ZLow_debug, exp_v); bad++; end
        // clear wins over every load asserted in the same cycle
        clear = 1; InPort_data_in = 32'h00001234;
        tick();
        idle();
        #1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h0);
        obs = '{r3_debug, r4_debug, r7_debug, pc_debug, ZHigh_debug, ZLow_debug, bus_data, OutPort_data_out};
        for (int i = 0; i < 8; i++) begin
            exp_v = exp_q.pop_front(); total++;
            if (obs[i] !== exp_v) begin $display("[TB] FAIL reset_out%0d got=%h exp=%h", i, obs[i], exp_v); bad++; end
        end
        InPortout = 1;
        #1;
        exp_v = 32'h0; total++;
        if (bus_data !== exp_v) begin $display("[TB] FAIL reset_inport got=%h exp=%h", bus_data, exp_v); bad++; end
        exp_q.push_back(32'h00001234);
        tick();
        exp_v = exp_q.pop_front(); total++;
        if (bus_data !== exp_v) begin $display("[TB] FAIL inport_sample got=%h exp=%h", bus_data, exp_v); bad++; end
        idle();
    endtask

    task automatic test_mdr_load();
        logic [31:0] vals [2] = '{32'h00000022, 32'h00000024};
        for (int k = 0; k < 2; k++) begin
            idle(); Mdatain = vals[k]; mdr_read = 1; MDRin = 1;
            tick();
            idle(); MDRout = 1;
            if (k == 0) r3in = 1; else r7in = 1;
            exp_q.push_back(vals[k]);
            tick();
            exp_v = exp_q.pop_front(); total++;
            if (k == 0) begin
                if (r3_debug !== exp_v) begin $display("[TB] FAIL mdr_to_r3 got=%h exp=%h", r3_debug, exp_v); bad++; end
            end else begin
                if (r7_debug !== exp_v) begin $display("[TB] FAIL mdr_to_r7 got=%h exp=%h", r7_debug, exp_v); bad++; end
            end
        end
        // With mdr_read low, MDR takes the bus instead of memory data
        idle(); Cout = 1; RY_immediate = 32'h00000055; Mdatain = 32'hFFFF0000; MDRin = 1;
        exp_q.push_back(32'h00000055);
        tick();
        idle(); MDRout = 1;
        #1;
        exp_v = exp_q.pop_front(); total++;
        if (bus_data !== exp_v) begin $display("[TB] FAIL mdr_from_bus got=%h exp=%h", bus_data, exp_v); bad++; end
        idle();
    endtask

    task automatic test_add();
        idle(); Rout[3] = 1; Yin = 1;
        tick();
        idle(); Rout[7] = 1; opcode = 5'b00000; ZLow_enable = 1;
        exp_q.push_back(32'h00000046);
        tick();
        exp_v = exp_q.pop_front(); total++;
        if (ZLow_debug !== exp_v) begin $display("[TB] FAIL add_zlow got=%h exp=%h", ZLow_debug, exp_v); bad++; end
        idle(); ZLowout = 1; r4in = 1;
        exp_q.push_back(32'h00000046);
        tick();
        exp_v = exp_q.pop_front(); total++;
        if (r4_debug !== exp_v) begin $display("[TB] FAIL add_r4 got=%h exp=%h", r4_debug, exp_v); bad++; end
        idle();
    endtask

    // Y = F0000011, B = 00000105 (shift/rotate amount 5)
    task automatic test_alu_ops();
        logic [4:0]  ops  [13] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00110,
                                   5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                                   5'b01100, 5'b01101, 5'b11111};
        logic [31:0] exps [13] = '{32'hF0000116, 32'hEFFFFF0C, 32'h00000001, 32'hF0000115,
                                   32'h07800000, 32'hFF800000, 32'h00000220, 32'h8F800000,
                                   32'h0000023E, 32'hFFFFFEFB, 32'hFFFFFEFA, 32'h00000106,
                                   32'h00000105};
        idle(); Cout = 1; RY_immediate = 32'hF0000011; Yin = 1;
        tick();
        for (int k = 0; k < 13; k++) begin
            idle(); Cout = 1; RY_immediate = 32'h00000105; opcode = ops[k];
            ZLow_enable = 1; ZHigh_enable = 1;
            exp_q.push_back(exps[k]);
            exp_q.push_back(32'h0);
            tick();
            exp_v = exp_q.pop_front(); total++;
            if (ZLow_debug !== exp_v) begin $display("[TB] FAIL alu_op%0d_zlow got=%h exp=%h", ops[k], ZLow_debug, exp_v); bad++; end
            exp_v = exp_q.pop_front(); total++;
            if (ZHigh_debug !== exp_v) begin $display("[TB] FAIL alu_op%0d_zhigh got=%h exp=%h", ops[k], ZHigh_debug, exp_v); bad++; end
        end
        idle();
    endtask

    task automatic test_mul_div();
        logic [31:0] ya  [7] = '{32'hFFFFFFFE, 32'h00010000, 32'h00000007, 32'h00000007,
                                 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h00000009};
        logic [31:0] ba  [7] = '{32'h00000003, 32'h00010000, 32'h00000002, 32'h00000000,
                                 32'h00000002, 32'h00000001, 32'h00000004};
        logic [4:0]  opa [7] = '{5'b00100, 5'b00100, 5'b00101, 5'b00101, 5'b00101, 5'b00000, 5'b00101};
        logic [31:0] zh  [7] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000,
                                 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        logic [31:0] zl  [7] = '{32'hFFFFFFFA, 32'h00000000, 32'h00000003, 32'h00000000,
                                 32'hFFFFFFFD, 32'h00000000, 32'h00000002};
        for (int k = 0; k < 7; k++) begin
            idle(); Cout = 1; RY_immediate = ya[k]; Yin = 1;
            tick();
            idle(); Cout = 1; RY_immediate = ba[k]; opcode = opa[k];
            ZLow_enable = 1; ZHigh_enable = 1;
            exp_q.push_back(zh[k]);
            exp_q.push_back(zl[k]);
            tick();
            exp_v = exp_q.pop_front(); total++;
            if (ZHigh_debug !== exp_v) begin $display("[TB] FAIL muldiv%0d_zhigh got=%h exp=%h", k, ZHigh_debug, exp_v); bad++; end
            exp_v = exp_q.pop_front(); total++;
            if (ZLow_debug !== exp_v) begin $display("[TB] FAIL muldiv%0d_zlow got=%h exp=%h", k, ZLow_debug, exp_v); bad++; end
        end
        idle();
    endtask

    task automatic test_fetch();
        for (int k = 0; k < 2; k++) begin
            idle(); PCout = 1; Yin = 1; opcode = 5'b01101; ZLow_enable = 1; MAR_enable = 1;
            exp_q.push_back(32'(k));
            exp_q.push_back(32'(k + 1));
            tick();
            exp_v = exp_q.pop_front(); total++;
            if (dut.mar !== exp_v) begin $display("[TB] FAIL fetch%0d_mar got=%h exp=%h", k, dut.mar, exp_v); bad++; end
            exp_v = exp_q.pop_front(); total++;
            if (ZLow_debug !== exp_v) begin $display("[TB] FAIL fetch%0d_zlow got=%h exp=%h", k, ZLow_debug, exp_v); bad++; end
            idle(); ZLowout = 1; PC_enable = 1;
            exp_q.push_back(32'(k + 1));
            tick();
            exp_v = exp_q.pop_front(); total++;
            if (pc_debug !== exp_v) begin $display("[TB] FAIL fetch%0d_pc got=%h exp=%h", k, pc_debug, exp_v); bad++; end
        end
        idle();
    endtask

    task automatic test_priority();
        idle(); Cout = 1; RY_immediate = 32'h00000111; HIin = 1;
        tick();
        idle(); Cout = 1; RY_immediate = 32'h00000222; LOin = 1;
        tick();
        // PC is 2 after the fetch steps
        idle(); PCout = 1; Cout = 1; RY_immediate = 32'h2A2B8000; #1;
        exp_v = 32'h00000002; total++;
        if (bus_data !== exp_v) begin $display("[TB] FAIL prio_pc_over_c got=%h exp=%h", bus_data, exp_v); bad++; end
        idle(); HIout = 1; LOout = 1; #1;
        exp_v = 32'h00000111; total++;
        if (bus_data !== exp_v) begin $display("[TB] FAIL prio_hi_over_lo got=%h exp=%h", bus_data, exp_v); bad++; end
        idle(); LOout = 1; Cout = 1; RY_immediate = 32'h0000ABCD; #1;
        exp_v = 32'h00000222; total++;
        if (bus_data !== exp_v) begin $display("[TB] FAIL prio_lo_over_c got=%h exp=%h", bus_data, exp_v); bad++; end
        idle(); Rout = 16'h0018; #1;
        exp_v = 32'h00000022; total++;
        if (bus_data !== exp_v) begin $display("[TB] FAIL prio_r3_over_r4 got=%h exp=%h", bus_data, exp_v); bad++; end
        idle(); Rout = 16'h0008; Cout = 1; RY_immediate = 32'h0BADF00D; #1;
        exp_v = 32'h0BADF00D; total++;
        if (bus_data !== exp_v) begin $display("[TB] FAIL prio_c_over_r3 got=%h exp=%h", bus_data, exp_v); bad++; end
        idle(); Cout = 1; RY_immediate = 32'h2A2B8000; IR_enable = 1;
        exp_q.push_back(32'h2A2B8000);
        #1;
        total++;
        if (bus_data !== 32'h2A2B8000) begin $display("[TB] FAIL imm_bus got=%h exp=%h", bus_data, 32'h2A2B8000); bad++; end
        tick();
        exp_v = exp_q.pop_front(); total++;
        if (dut.ir !== exp_v) begin $display("[TB] FAIL imm_ir got=%h exp=%h", dut.ir, exp_v); bad++; end
        idle();
    endtask

    task automatic test_back_to_back();
        // R0 behaves as an ordinary register
        idle(); Cout = 1; RY_immediate = 32'h00000005; enable[0] = 1;
        tick();
        idle(); Rout[0] = 1; #1;
        exp_v = 32'h00000005; total++;
        if (bus_data !== exp_v) begin $display("[TB] FAIL r0_load got=%h exp=%h", bus_data, exp_v); bad++; end
        // Reading and writing R2 in the same cycle holds its value
        idle(); Cout = 1; RY_immediate = 32'h00000077; enable[2] = 1;
        tick();
        idle(); Rout[2] = 1; enable[2] = 1;
        exp_q.push_back(32'h00000077);
        tick();
        idle(); Rout[2] = 1; #1;
        exp_v = exp_q.pop_front(); total++;
        if (bus_data !== exp_v) begin $display("[TB] FAIL r2_hold got=%h exp=%h", bus_data, exp_v); bad++; end
        // One bus value into several destinations at once
        idle(); Cout = 1; RY_immediate = 32'h13572468; OutPort_enable = 1; PC_enable = 1;
        exp_q.push_back(32'h13572468);
        exp_q.push_back(32'h13572468);
        tick();
        exp_v = exp_q.pop_front(); total++;
        if (OutPort_data_out !== exp_v) begin $display("[TB] FAIL outport got=%h exp=%h", OutPort_data_out, exp_v); bad++; end
        exp_v = exp_q.pop_front(); total++;
        if (pc_debug !== exp_v) begin $display("[TB] FAIL multi_load_pc got=%h exp=%h", pc_debug, exp_v); bad++; end
        idle();
    endtask

    initial begin
        idle();
        InPort_data_in = '0;
        clear = 1;
        tick();
        tick();
        clear = 0;
        test_reset();
        test_mdr_load();
        test_add();
        test_alu_ops();
        test_mul_div();
        test_fetch();
        test_priority();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
